btb_update_sched: RTL and testbench
===================================

Name: btb_update_sched

Overview:
- Buffers committed branch-target updates from the EX/MEM branch resolution logic, i.e. the btb_load strobe plus the branch PC and target.
- Schedules those updates into the single-ported BTB so that writes only occur in cycles when fetch is not reading it.
- Guarantees forward progress by forcing a fetch stall when fetch has starved the writer for too long.
- Sits between the branch resolution stage and the BTB write port; fetch_stall feeds the IF-stage hazard logic.

Parameters:
- DEPTH, 4, number of pending-update queue entries (power of two, ≥2).
- PC_WIDTH, 16, width of branch PC and target.
- STARVE_LIMIT, 8, consecutive blocked cycles with pending work before a forced write (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- upd_valid  input  1  branch resolved taken; enqueue request (btb_load).
- upd_pc  input  PC_WIDTH  branch instruction PC.
- upd_target  input  PC_WIDTH  resolved branch target.
- fetch_req  input  1  fetch stage reads the BTB this cycle.
- q_full  output  1  queue holds DEPTH entries (registered); pipeline should hold retirement of branches.
- q_count  output  $clog2(DEPTH+1)  current occupancy.
- btb_we  output  1  BTB write enable.
- btb_waddr  output  PC_WIDTH  PC written (head entry).
- btb_wdata  output  PC_WIDTH  target written (head entry).
- fetch_stall  output  1  asserted in FORCE; fetch must not read the BTB.
- err_overflow  output  1  sticky; an update was dropped.

Behaviour:
- Reset (async, reset_n=0):
  - count=0, head=tail=0, state=IDLE, starve counter=0, err_overflow=0.
  - btb_we=0, fetch_stall=0, q_full=0.
- Queue ordering and enqueue:
  - Circular FIFO, oldest first; pointers wrap modulo DEPTH.
  - Enqueue is registered: an update presented in cycle N is visible to the writer in cycle N+1. There is no bypass.
- Pop:
  - btb_we = (count≠0) && (!fetch_req || state==FORCE). This is combinational from fetch_req.
  - btb_waddr/btb_wdata are the head entry; they are don't-care when btb_we=0.
  - A pop occurs in exactly the cycles where btb_we=1, and the head advances at that clock edge.
- Coalescing:
  - If upd_valid and upd_pc matches a valid entry that is not being popped this cycle, overwrite that entry's target. Count is unchanged.
  - If the match is the head being popped this cycle, enqueue as a new entry.
  - At most one entry per PC exists in the queue.
- Full:
  - upd_valid while count==DEPTH and no pop this cycle and no coalesce hit: the update is dropped and err_overflow is set. err_overflow clears only on reset.
  - Pop and enqueue in the same cycle while full: both happen; count stays DEPTH.
- State machine:
  - IDLE: count==0.
    - Enqueue → PENDING.
  - PENDING: count>0.
    - Starve counter increments each cycle with count>0 and fetch_req=1.
    - Starve counter resets to 0 on any pop.
    - Counter reaching STARVE_LIMIT → FORCE next cycle.
    - Count reaching 0 with no enqueue → IDLE.
  - FORCE:
    - fetch_stall=1, driven registered from state.
    - Writes the head regardless of fetch_req: exactly one pop.
    - Then → PENDING if count after pop >0, else IDLE. Starve counter is 0.
- Enqueue in any state is independent of the state machine. Enqueue in FORCE is accepted normally.
- Starve counter width is $clog2(STARVE_LIMIT+1) and saturates at STARVE_LIMIT.
- q_count and q_full are registered, reflecting post-edge occupancy.

Test Plan:
- Basic write: fetch_req=0; in cycle 0 pulse upd_valid, pc=0x3000, tgt=0x3020 → cycle 1: btb_we=1, waddr=0x3000, wdata=0x3020; cycle 2: q_count=0, state IDLE.
- Starvation: STARVE_LIMIT=8, one entry pending, fetch_req held 1 →
  - btb_we=0 for 8 cycles.
  - Then one cycle with fetch_stall=1 and btb_we=1 writing the entry.
  - Then fetch_stall=0 and q_count=0.
- Coalesce: fetch_req=1; enqueue 0x3000→0x3020, then 0x3000→0x3040 → q_count=1; after fetch_req=0, a single write with wdata=0x3040.
- Overflow: fetch_req=1; enqueue PCs 0x3000, 0x3002, 0x3004, 0x3006 → q_full=1. Then enqueue 0x3008 with no pop →
  - dropped, err_overflow=1.
  - Later drain writes only the 4 PCs, in order.
- Full push+pop: queue full; fetch_req=0 and new PC 0x300A in the same cycle → head written, q_count stays 4, and 0x300A is written last.
- Reset mid-FORCE: assert reset_n=0 while fetch_stall=1 → fetch_stall, btb_we and q_count drop to 0 immediately (async). After release, no write occurs until a new enqueue.

Source files
------------

// File: rtl/btb_update_sched.sv
// Pending-update queue for branch-target writes into a single-ported BTB.
// Writes steal idle fetch cycles; a starvation timer forces a fetch stall.
module btb_update_sched #(
  parameter int DEPTH        = 4,
  parameter int PC_WIDTH     = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       upd_valid,
  input  logic [PC_WIDTH-1:0]        upd_pc,
  input  logic [PC_WIDTH-1:0]        upd_target,
  input  logic                       fetch_req,
  output logic                       q_full,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       btb_we,
  output logic [PC_WIDTH-1:0]        btb_waddr,
  output logic [PC_WIDTH-1:0]        btb_wdata,
  output logic                       fetch_stall,
  output logic                       err_overflow
);

  // state   | meaning
  // IDLE    | queue empty
  // PENDING | updates waiting for a cycle without a fetch read
  // FORCE   | fetch stalled, head written unconditionally

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_FORCE} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q  [DEPTH];
  logic [PC_WIDTH-1:0]   pc_d  [DEPTH];
  logic [PC_WIDTH-1:0]   tgt_q [DEPTH];
  logic [PC_WIDTH-1:0]   tgt_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  err_q, err_d;
  logic                  full_q, full_d;
  logic                  stall_q, stall_d;

  logic                  pop, enq, drop, hit;
  logic [PW-1:0]         hit_idx;
  logic [PW-1:0]         off;

  always_comb begin
    pop     = (count_q != '0) && (!fetch_req || state_q == S_FORCE);
    hit     = 1'b0;
    hit_idx = '0;
    off     = '0;
    // The head being popped this cycle is not a coalesce target; the update
    // becomes a fresh entry instead, so the new target is still written.
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ((CW'(off) < count_q) && (pc_q[i] == upd_pc) &&
          !(pop && (PW'(i) == head_q))) begin
        hit     = upd_valid;
        hit_idx = PW'(i);
      end
    end

    enq  = upd_valid && !hit && ((count_q != CW'(DEPTH)) || pop);
    drop = upd_valid && !hit && (count_q == CW'(DEPTH)) && !pop;

    pc_d  = pc_q;
    tgt_d = tgt_q;
    if (hit) tgt_d[hit_idx] = upd_target;
    if (enq) begin
      pc_d[tail_q]  = upd_pc;
      tgt_d[tail_q] = upd_target;
    end

    head_d  = pop ? head_q + PW'(1) : head_q;
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(pop);
    err_d   = err_q | drop;

    starve_d = starve_q;
    if (pop)
      starve_d = '0;
    else if ((count_q != '0) && fetch_req && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);

    // Entering FORCE on the edge the counter reaches the limit gives exactly
    // STARVE_LIMIT blocked cycles before the forced write.
    if (state_q == S_FORCE)
      state_d = (count_d != '0) ? S_PENDING : S_IDLE;
    else if (count_d == '0)
      state_d = S_IDLE;
    else if (starve_d == SW'(STARVE_LIMIT))
      state_d = S_FORCE;
    else
      state_d = S_PENDING;

    full_d  = (count_d == CW'(DEPTH));
    stall_d = (state_d == S_FORCE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '{default: '0};
      tgt_q    <= '{default: '0};
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      full_q   <= full_d;
      stall_q  <= stall_d;
    end
  end

  assign btb_we       = pop;
  assign btb_waddr    = pc_q[head_q];
  assign btb_wdata    = tgt_q[head_q];
  assign q_count      = count_q;
  assign q_full       = full_q;
  assign fetch_stall  = stall_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_btb_update_sched.sv
// Scoreboard bench for btb_update_sched: expected BTB writes are queued as
// updates are driven and matched against every observed write.
module tb_btb_update_sched;

  logic        clk;
  logic        reset_n;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        fetch_req;
  logic        q_full;
  logic [2:0]  q_count;
  logic        btb_we;
  logic [15:0] btb_waddr;
  logic [15:0] btb_wdata;
  logic        fetch_stall;
  logic        err_overflow;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] tgt;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  btb_update_sched #(.DEPTH(4), .PC_WIDTH(16), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .fetch_req    (fetch_req),
    .q_full       (q_full),
    .q_count      (q_count),
    .btb_we       (btb_we),
    .btb_waddr    (btb_waddr),
    .btb_wdata    (btb_wdata),
    .fetch_stall  (fetch_stall),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [15:0] pc, input logic [15:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  // Write monitor: every BTB write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && btb_we) begin
      if (exp_q.size() == 0) begin
        chk("unexp_we", {31'd0, btb_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {16'd0, btb_waddr}, {16'd0, e.pc});
        chk("wr_data", {16'd0, btb_wdata}, {16'd0, e.tgt});
      end
    end
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_target = '0;
    fetch_req  = 1'b0;
    #12;
    chk("rst_cnt",   {29'd0, q_count}, 32'd0);
    chk("rst_we",    {31'd0, btb_we}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_full",  {31'd0, q_full}, 32'd0);
    chk("rst_err",   {31'd0, err_overflow}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick();

    // basic write on an idle BTB port
    exp_q.push_back('{16'h3000, 16'h3020});
    enq(16'h3000, 16'h3020);
    @(negedge clk);
    chk("basic_we", {31'd0, btb_we}, 32'd1);
    tick();
    @(negedge clk);
    chk("basic_cnt", {29'd0, q_count}, 32'd0);
    chk("basic_idle_we", {31'd0, btb_we}, 32'd0);
    tick();

    // starvation: 8 blocked cycles, then one forced write
    fetch_req = 1'b1;
    exp_q.push_back('{16'h3100, 16'h3120});
    enq(16'h3100, 16'h3120);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("starve_we", {31'd0, btb_we}, 32'd0);
      chk("starve_stall", {31'd0, fetch_stall}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("force_stall", {31'd0, fetch_stall}, 32'd1);
    chk("force_we", {31'd0, btb_we}, 32'd1);
    tick();
    @(negedge clk);
    chk("post_force_stall", {31'd0, fetch_stall}, 32'd0);
    chk("post_force_cnt", {29'd0, q_count}, 32'd0);
    tick();

    // coalesce two updates to the same PC
    enq(16'h3000, 16'h3020);
    enq(16'h3000, 16'h3040);
    @(negedge clk);
    chk("coal_cnt", {29'd0, q_count}, 32'd1);
    exp_q.push_back('{16'h3000, 16'h3040});
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("coal_we", {31'd0, btb_we}, 32'd1);
    tick();
    tick();
    chk("coal_sb", exp_q.size(), 32'd0);
    chk("coal_cnt_end", {29'd0, q_count}, 32'd0);

    // overflow: fill, drop one, then push+pop while full
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{16'h3000 + 16'(2 * i), 16'h5000 + 16'(2 * i)});
      enq(16'h3000 + 16'(2 * i), 16'h5000 + 16'(2 * i));
    end
    @(negedge clk);
    chk("ovf_full", {31'd0, q_full}, 32'd1);
    tick();
    enq(16'h3008, 16'h5008);
    @(negedge clk);
    chk("ovf_err", {31'd0, err_overflow}, 32'd1);
    chk("ovf_cnt", {29'd0, q_count}, 32'd4);
    tick();
    exp_q.push_back('{16'h300A, 16'h500A});
    fetch_req = 1'b0;
    enq(16'h300A, 16'h500A);
    fetch_req = 1'b1;
    @(negedge clk);
    chk("fp_cnt", {29'd0, q_count}, 32'd4);
    chk("fp_full", {31'd0, q_full}, 32'd1);
    tick();
    fetch_req = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("ovf_drain_sb", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("ovf_drain_cnt", {29'd0, q_count}, 32'd0);
    chk("ovf_err_sticky", {31'd0, err_overflow}, 32'd1);
    tick();

    // asynchronous reset while in FORCE
    fetch_req = 1'b1;
    exp_q.push_back('{16'h3200, 16'h3220});
    enq(16'h3200, 16'h3220);
    n = 0;
    @(negedge clk);
    while (!fetch_stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rf_force_seen", {31'd0, fetch_stall}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rf_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rf_we", {31'd0, btb_we}, 32'd0);
    chk("rf_cnt", {29'd0, q_count}, 32'd0);
    chk("rf_err", {31'd0, err_overflow}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      fetch_req = k[0];
      @(negedge clk);
      chk("rf_no_we", {31'd0, btb_we}, 32'd0);
      tick();
    end
    fetch_req = 1'b0;
    exp_q.push_back('{16'h3300, 16'h3330});
    enq(16'h3300, 16'h3330);
    tick();
    tick();
    chk("final_sb", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
